// File: rtl/moving_sum_decoder.sv
// -----------------------------------------------------------------------------
// moving_sum_decoder
//
// Recovers a sample stream x[t] from its moving-window sum
//   s[t] = sum(x[t-W+1..t]) mod 2**DW,   W = 2**N
// using the recurrence x[t] = s[t] - s[t-1] + x[t-W] (mod 2**DW).
// A W-deep history of recovered samples supplies x[t-W]; a previous-sum
// register supplies s[t-1]. Both advance only on in_valid cycles.
// Output latency is one clock.
//
// Optional feature: define MSD_FLUSH_EN to add the synchronous 'flush' input,
// which clears the history and restarts the fill sequence.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous stream restart (MSD_FLUSH_EN builds only)
//   in_valid   qualifies in_sum
//   in_sum     moving-window sum s[t], DW bits
//   out_valid  in_valid delayed by one cycle
//   out_samp   recovered sample x[t]; holds its value when out_valid=0
//   filled     high once W samples have been decoded since reset/flush
// -----------------------------------------------------------------------------
module moving_sum_decoder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef MSD_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          in_valid,
    input  logic [DW-1:0] in_sum,
    output logic          out_valid,
    output logic [DW-1:0] out_samp,
    output logic          filled
);

    localparam int         W     = 2 ** N;
    localparam logic [N:0] W_CNT = (N + 1)'(W);

    typedef enum logic {
        FILL,
        STEADY
    } state_e;

    state_e        state_q,     state_d;
    logic [N:0]    fill_cnt_q,  fill_cnt_d;
    logic [DW-1:0] prev_sum_q,  prev_sum_d;
    logic [DW-1:0] hist_q [W];
    logic [DW-1:0] hist_d [W];
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_samp_q,  out_samp_d;
    logic          filled_q,    filled_d;

    logic          clr;
    logic [DW-1:0] samp;

    // hist_q[0] holds the newest sample, hist_q[W-1] the one decoded W valid
    // cycles ago, which is exactly the x[t-W] tap.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        prev_sum_d  = prev_sum_q;
        hist_d      = hist_q;
        filled_d    = filled_q;
        out_valid_d = in_valid;
        out_samp_d  = out_samp_q;
        clr         = 1'b0;
`ifdef MSD_FLUSH_EN
        clr         = flush;
`endif

        // A flush clears the stream state first, so a sample arriving in the
        // same cycle is decoded against zeroed history as a fresh stream.
        if (clr) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            prev_sum_d = '0;
            filled_d   = 1'b0;
            for (int i = 0; i < W; i++) begin
                hist_d[i] = '0;
            end
        end

        samp = in_sum - prev_sum_d + hist_d[W-1];

        if (in_valid) begin
            out_samp_d = samp;
            prev_sum_d = in_sum;
            for (int i = W - 1; i > 0; i--) begin
                hist_d[i] = hist_d[i-1];
            end
            hist_d[0] = samp;

            if (state_d == FILL) begin
                fill_cnt_d = fill_cnt_d + 1'b1;
                // filled rises together with the W-th sample's out_valid.
                if (fill_cnt_d == W_CNT) begin
                    state_d  = STEADY;
                    filled_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the blocking
    // assignments above are confined to the combinational next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            prev_sum_q  <= '0;
            out_valid_q <= 1'b0;
            out_samp_q  <= '0;
            filled_q    <= 1'b0;
            // NOTE: the history line is a small flop array, not RAM, and it
            // must read as zero for the first W samples after reset, so every
            // entry is reset here.
            for (int i = 0; i < W; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            prev_sum_q  <= prev_sum_d;
            out_valid_q <= out_valid_d;
            out_samp_q  <= out_samp_d;
            filled_q    <= filled_d;
            hist_q      <= hist_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_samp  = out_samp_q;
    assign filled    = filled_q;

endmodule

// File: tb/tb_moving_sum_decoder.sv
// -----------------------------------------------------------------------------
// tb_moving_sum_decoder
//
// Self-checking bench for moving_sum_decoder (N=4, DW=8). The reference model
// keeps the list of samples x sent since the last reset/flush, builds each
// in_sum as the plain sum of the last W of them, and expects out_samp to equal
// the sample itself, out_valid to mirror in_valid one cycle later, and filled
// to be set once W samples have been sent.
// -----------------------------------------------------------------------------
module tb_moving_sum_decoder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int W  = 2 ** N;

    logic          clk;
    logic          rst_n;
`ifdef MSD_FLUSH_EN
    logic          flush;
`endif
    logic          in_valid;
    logic [DW-1:0] in_sum;
    logic          out_valid;
    logic [DW-1:0] out_samp;
    logic          filled;

    moving_sum_decoder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MSD_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_samp  (out_samp),
        .filled    (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int xs[$];
    int last_out = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int window_sum();
        int s = 0;
        int lo;
        lo = (xs.size() > W) ? xs.size() - W : 0;
        for (int i = lo; i < xs.size(); i++) s += xs[i];
        return s % 256;
    endfunction

    // One clock of stimulus; invalid cycles carry garbage in_sum.
    task automatic step(input bit v, input int x);
        @(negedge clk);
        in_valid = v;
        if (v) begin
            xs.push_back(x % 256);
            in_sum = 8'(window_sum());
        end else begin
            in_sum = 8'($urandom);
        end
        @(posedge clk);
        #1;
        if (v) last_out = x % 256;
        check("out_valid", out_valid, v);
        check("out_samp", out_samp, last_out);
        check("filled", filled, (xs.size() >= W) ? 1 : 0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_samp", out_samp, 0);
        check("rst_filled", filled, 0);
        xs.delete();
        last_out = 0;
        @(posedge clk);
        #1;
        check("rst_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sum   = '0;
`ifdef MSD_FLUSH_EN
        flush    = 1'b0;
`endif
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_out_samp", out_samp, 0);
        check("init_filled", filled, 0);
        #20 rst_n = 1'b1;

        // No output activity before the first valid input.
        for (int i = 0; i < 3; i++) step(1'b0, 0);

        // Constant x=1: in_sum ramps 1..16 then saturates at 16.
        for (int i = 0; i < 20; i++) step(1'b1, 1);

        // Constant x=200 exercises modular wrap-around of the sum.
        pulse_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 200);

        // Random x with a bubble every third cycle.
        pulse_reset();
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 2) step(1'b0, 0);
            else            step(1'b1, int'($urandom_range(0, 255)));
        end

        // Random back-to-back stream with irregular bubbles.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 0);
            else                           step(1'b1, int'($urandom_range(0, 255)));
        end

        // Mid-stream reset after 20 samples, then an impulse.
        pulse_reset();
        for (int i = 0; i < 20; i++) step(1'b1, int'($urandom_range(0, 255)));
        pulse_reset();
        step(1'b1, 5);
        for (int i = 0; i < 20; i++) step(1'b1, 0);

        // Sample 30 of a fresh stream: flushed restart (flush builds) or
        // uninterrupted decode (default build).
        pulse_reset();
        for (int i = 0; i < 29; i++) step(1'b1, int'($urandom_range(0, 255)));
`ifdef MSD_FLUSH_EN
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sum   = 8'd7;
        xs.delete();
        xs.push_back(7);
        last_out = 7;
        @(posedge clk);
        #1;
        check("flush_out_valid", out_valid, 1);
        check("flush_out_samp", out_samp, 7);
        check("flush_filled", filled, 0);
        @(negedge clk);
        flush = 1'b0;
`endif
        for (int i = 0; i < 25; i++) step(1'b1, int'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
